axis_byte_packer: RTL and testbench

Single-clock AXI-Stream upsizer sitting directly downstream of the byte-wide read path of the clock-crossing AXIS FIFO. It packs 8-bit beats into 32-bit little-endian words and marks valid byte lanes with `m_axis_tkeep`. It flushes partial words on `s_axis_tlast` and, optionally, on an input idle timeout. It feeds the 32-bit readout/transport logic and keeps simple frame and flush counters for status registers.

---
 rtl/axis_byte_packer.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_byte_packer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: AXI-Stream 8-bit to 32-bit little-endian upsizer.
// Bytes fill lanes 0..3 of an accumulator; a word is emitted when lane 3 is
// written, on s_axis_tlast, or (optionally) after an input idle timeout.
// Optional feature macro: AXIS_BYTE_PACKER_TIMEOUT_EN builds the idle counter,
// timeout flush and flush_count; without it flush_count is tied to zero.
module axis_byte_packer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            tready_q;
    logic [3:0][7:0] acc_q, acc_d;
    logic [3:0]      keep_q, keep_d;
    logic [1:0]      lane_q, lane_d;
    logic            last_q, last_d;

    logic [31:0]     out_data_q, out_data_d;
    logic [3:0]      out_keep_q, out_keep_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     frame_q, frame_d;

    logic            out_free;
    logic            accept;
    logic            timeout_hit;
    logic [3:0][7:0] merged_data;
    logic [3:0]      merged_keep;

    logic            load;
    logic [31:0]     load_data;
    logic [3:0]      load_keep;
    logic            load_last;

    // The output register can take a new word when empty or being drained now.
    assign out_free = !out_valid_q || m_axis_tready;
    assign accept   = s_axis_tvalid && tready_q;

    // Accumulator contents with the incoming byte dropped into the current lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_data[gi] = (accept && (lane_q == 2'(gi))) ? s_axis_tdata : acc_q[gi];
            assign merged_keep[gi] = keep_q[gi] || (accept && (lane_q == 2'(gi)));
        end
    endgenerate

`ifdef AXIS_BYTE_PACKER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_q, idle_d;
    logic [15:0] flush_q, flush_d;
    logic        idle_run;

    // Idle means a partial word is held in FILL and no byte arrives this cycle.
    assign idle_run    = (state_q == FILL) && (lane_q != 2'd0) && !accept;
    assign timeout_hit = idle_run && (idle_q == TIMEOUT_LIMIT);

    // Idle counter advances on idle cycles and clears otherwise (including on flush).
    always_comb begin
        idle_d  = 16'd0;
        flush_d = flush_q;
        if (timeout_hit) begin
            flush_d = flush_q + 16'd1;
        end else if (idle_run) begin
            idle_d = idle_q + 16'd1;
        end
    end

    // Idle counter and flush counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q  <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            idle_q  <= idle_d;
            flush_q <= flush_d;
        end
    end

    assign flush_count = flush_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign flush_count    = 16'd0;
`endif

    // Next-state logic: fill lanes, complete words, and hand them to the output register.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        keep_d    = keep_q;
        lane_d    = lane_q;
        last_d    = last_q;
        load      = 1'b0;
        load_data = acc_q;
        load_keep = keep_q;
        load_last = last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if ((lane_q == 2'd3) || s_axis_tlast) begin
                        if (out_free) begin
                            load      = 1'b1;
                            load_data = merged_data;
                            load_keep = merged_keep;
                            load_last = s_axis_tlast;
                            acc_d     = '0;
                            keep_d    = 4'd0;
                            lane_d    = 2'd0;
                            last_d    = 1'b0;
                        end else begin
                            acc_d   = merged_data;
                            keep_d  = merged_keep;
                            last_d  = s_axis_tlast;
                            state_d = FULL;
                        end
                    end else begin
                        acc_d  = merged_data;
                        keep_d = merged_keep;
                        lane_d = lane_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    // Timeout closes the partial word without ending the frame.
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = acc_q;
                        load_keep = keep_q;
                        load_last = 1'b0;
                        acc_d     = '0;
                        keep_d    = 4'd0;
                        lane_d    = 2'd0;
                        last_d    = 1'b0;
                    end else begin
                        last_d  = 1'b0;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = acc_q;
                    load_keep = keep_q;
                    load_last = last_q;
                    acc_d     = '0;
                    keep_d    = 4'd0;
                    lane_d    = 2'd0;
                    last_d    = 1'b0;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output register: a load replaces the word; a handshake without a load empties it.
    always_comb begin
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        frame_d     = frame_q;
        if (load) begin
            out_data_d  = load_data;
            out_keep_d  = load_keep;
            out_last_d  = load_last;
            out_valid_d = 1'b1;
        end else if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && m_axis_tready && out_last_q) begin
            frame_d = frame_q + 16'd1;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            tready_q    <= 1'b0;
            acc_q       <= '0;
            keep_q      <= 4'd0;
            lane_q      <= 2'd0;
            last_q      <= 1'b0;
            out_data_q  <= 32'd0;
            out_keep_q  <= 4'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            tready_q    <= (state_d == FILL);
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            lane_q      <= lane_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            frame_q     <= frame_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_valid_q;
    assign frame_count   = frame_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer: random and directed byte streams checked by a
// scoreboard fed from a frame/word-level reference model.
module tb_axis_byte_packer;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] frame_count;
    logic [15:0] flush_count;

    axis_byte_packer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frame_count   (frame_count),
        .flush_count   (flush_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] cur[$];
    int         idle_cnt;
    int         exp_frames;
    int         exp_flush;
    int         acc_count;
    int         checks;
    int         errors;
    int         rdy_mode;
    bit         verbose;
    bit         hold_pending;
    word_t      held;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Build the expected word from the bytes collected so far.
    function automatic word_t make_word(input logic last);
        word_t w;
        w.data = 32'd0;
        for (int k = 0; k < cur.size(); k++) begin
            w.data = w.data | (32'(cur[k]) << (8 * k));
        end
        w.keep = 4'((1 << cur.size()) - 1);
        w.last = last;
        return w;
    endfunction

    // Downstream ready: 0 random, 1 always ready, 2 always stalled.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_tready = ($urandom_range(0, 3) != 0);
                1:       m_tready = 1'b1;
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor and reference model: everything seen mid-cycle happens at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pending) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", m_tdata, held.data);
                check("hold_keep", 32'(m_tkeep), 32'(held.keep));
                check("hold_last", 32'(m_tlast), 32'(held.last));
            end
            if (m_tvalid) begin
                if (m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got data=%h keep=%b last=%b expected none", m_tdata, m_tkeep, m_tlast);
                    end else begin
                        word_t e;
                        e = exp_q.pop_front();
                        check("word_data", m_tdata, e.data);
                        check("word_keep", 32'(m_tkeep), 32'(e.keep));
                        check("word_last", 32'(m_tlast), 32'(e.last));
                        if (e.last) exp_frames++;
                        if (verbose) $display("word data=%h keep=%b last=%b", m_tdata, m_tkeep, m_tlast);
                    end
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    held.data = m_tdata;
                    held.keep = m_tkeep;
                    held.last = m_tlast;
                end
            end else begin
                hold_pending = 1'b0;
            end

            if (s_tvalid && s_tready) begin
                acc_count++;
                idle_cnt = 0;
                cur.push_back(s_tdata);
                if (cur.size() == 4 || s_tlast) begin
                    exp_q.push_back(make_word(s_tlast));
                    cur.delete();
                end
            end else if (cur.size() != 0) begin
                idle_cnt++;
`ifdef AXIS_BYTE_PACKER_TIMEOUT_EN
                if (idle_cnt == TO + 1) begin
                    exp_q.push_back(make_word(1'b0));
                    cur.delete();
                    idle_cnt = 0;
                    exp_flush++;
                end
`endif
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int wait_cnt;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        wait_cnt = 0;
        @(negedge clk);
        while (!s_tready && wait_cnt < 2000) begin
            wait_cnt++;
            @(negedge clk);
        end
        if (!s_tready) check("send_ready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'd0;
        exp_q.delete();
        cur.delete();
        idle_cnt     = 0;
        exp_frames   = 0;
        exp_flush    = 0;
        hold_pending = 1'b0;
        @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tkeep", 32'(m_tkeep), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_flush_count", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_s_tready_low", 32'(s_tready), 32'd0);
        @(negedge clk);
        check("rel_s_tready_high", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Let every expected word drain, then compare the status counters to the model.
    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("frame_count", 32'(frame_count), 32'(16'(exp_frames)));
        check("flush_count", 32'(flush_count), 32'(16'(exp_flush)));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        int gap;
        int r;
        rst          = 1'b0;
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        s_tdata      = 8'd0;
        rdy_mode     = 1;
        verbose      = 1'b1;
        checks       = 0;
        errors       = 0;
        acc_count    = 0;
        idle_cnt     = 0;
        exp_frames   = 0;
        exp_flush    = 0;
        hold_pending = 1'b0;
        #3;
        do_reset();

        // Full four-byte frame.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        drain();
        check("frame_count_one", 32'(frame_count), 32'd1);

        // Short frames: two bytes, then one byte.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
        drain();

        // Twelve back-to-back bytes against a stalled sink.
        rdy_mode = 2;
        base = acc_count;
        fork
            begin
                for (int i = 0; i < 12; i++) send(8'(8'hA0 + i), (i == 11));
            end
        join_none
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_accepted", 32'(acc_count - base), 32'd8);
        check("stall_s_tready", 32'(s_tready), 32'd0);
        check("stall_m_tvalid", 32'(m_tvalid), 32'd1);
        rdy_mode = 1;
        wait fork;
        drain();

`ifdef AXIS_BYTE_PACKER_TIMEOUT_EN
        // Partial word flushed by the idle timeout.
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n = i;
            if (m_tvalid) break;
        end
        check("timeout_latency", 32'(n), 32'(TO + 2));
        @(posedge clk);
        #1;
        drain();
        check("flush_count_one", 32'(flush_count), 32'd1);

        // A byte arriving on the expiry cycle cancels the flush.
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        repeat (TO) @(posedge clk);
        #1;
        send(8'h64, 1'b1);
        drain();
        check("flush_cancelled", 32'(flush_count), 32'd1);
`endif

        // Reset in the middle of a frame discards the partial word.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        do_reset();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        drain();

        // Random bytes, random frame ends, random gaps and random sink stalls.
        rdy_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12) gap = 0;
            else if (r < 18) gap = $urandom_range(1, 3);
            else gap = $urandom_range(TO - 1, TO + 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(8'($urandom), ($urandom_range(0, 6) == 0));
        end
        drain();

        // Frame counter wrap: 65537 single-byte frames.
        do_reset();
        verbose  = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 65537; i++) send(8'(i), 1'b1);
        drain();
        check("frame_count_wrap", 32'(frame_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
